// File: rtl/oled_text_buffer_if.sv
// Character-write bus and beat stream of the OLED text buffer.
// The buffer side uses the slave modport; the host/renderer side uses master.
interface oled_text_buffer_if;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;

    // Character write port
    logic              we_ip;
    logic [ADDR_W-1:0] write_addr_ip;
    logic [DATA_W-1:0] write_data_ip;

    // Frame stream toward the renderer
    logic              char_valid_o;
    logic              char_ready_i;
    logic [DATA_W-1:0] char_data_o;
    logic [ADDR_W-1:0] char_addr_o;
    logic              frame_first_o;
    logic              frame_last_o;

    modport slave (
        input  we_ip,
        input  write_addr_ip,
        input  write_data_ip,
        input  char_ready_i,
        output char_valid_o,
        output char_data_o,
        output char_addr_o,
        output frame_first_o,
        output frame_last_o
    );

    modport master (
        output we_ip,
        output write_addr_ip,
        output write_data_ip,
        output char_ready_i,
        input  char_valid_o,
        input  char_data_o,
        input  char_addr_o,
        input  frame_first_o,
        input  frame_last_o
    );
endinterface

// File: rtl/oled_text_buffer.sv
// 4x16 character buffer for an OLED panel. Cells are cleared after reset and
// streamed out one beat per cell (valid/ready) whenever a frame is started.
// Optional feature: define OLED_TEXT_BUF_READBACK_EN to add the combinational
// readback port (rb_addr_i / rb_data_o).
module oled_text_buffer #(
    parameter logic [7:0] CLEAR_CHAR   = 8'h20,
    parameter bit         AUTO_REFRESH = 1'b1
) (
    input  logic                  sysclk,
    input  logic                  cpu_resetn,
    oled_text_buffer_if.slave     bus,
    input  logic                  refresh_i,
    output logic                  clear_busy_o
`ifdef OLED_TEXT_BUF_READBACK_EN
    ,
    input  logic [5:0]            rb_addr_i,
    output logic [7:0]            rb_data_o
`endif
);

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CELLS  = 64;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_LOAD    = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              dirty_q, dirty_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              first_q, first_d;
    logic              last_q, last_d;

    logic [DATA_W-1:0] cells_q [CELLS];

    logic              cell_we;
    logic [ADDR_W-1:0] cell_waddr;
    logic [DATA_W-1:0] cell_wdata;
    logic              wr_accept;

    // Host writes are accepted everywhere except during the clear sweep.
    assign wr_accept = bus.we_ip && (state_q != ST_CLEAR);

    // Single cell write port shared by the clear sweep and host writes.
    always_comb begin
        cell_we    = 1'b0;
        cell_waddr = bus.write_addr_ip;
        cell_wdata = bus.write_data_ip;
        if (state_q == ST_CLEAR) begin
            cell_we    = 1'b1;
            cell_waddr = clr_cnt_q;
            cell_wdata = CLEAR_CHAR;
        end else if (bus.we_ip) begin
            cell_we    = 1'b1;
        end
    end

    // Character storage; contents are only defined once the clear sweep ends.
    always_ff @(posedge sysclk) begin
        if (cell_we) begin
            cells_q[cell_waddr] <= cell_wdata;
        end
    end

    // State and output registers.
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            rd_ptr_q  <= '0;
            dirty_q   <= 1'b0;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            dirty_q   <= dirty_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    // Next-state logic: clear sweep, frame start, per-cell load and present.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rd_ptr_d  = rd_ptr_q;
        dirty_d   = dirty_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        data_d    = data_q;
        addr_d    = addr_q;
        first_d   = first_q;
        last_d    = last_q;

        unique case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                    dirty_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                if ((dirty_q && AUTO_REFRESH) || refresh_i) begin
                    state_d  = ST_LOAD;
                    dirty_d  = 1'b0;
                    rd_ptr_d = '0;
                end
            end
            ST_LOAD: begin
                // Snapshot is taken before any write at this edge lands.
                data_d  = cells_q[rd_ptr_q];
                addr_d  = rd_ptr_q;
                first_d = (rd_ptr_q == '0);
                last_d  = (rd_ptr_q == LAST_CELL);
                valid_d = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.char_ready_i) begin
                    valid_d = 1'b0;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                    if (rd_ptr_q == LAST_CELL) begin
                        state_d = ST_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        state_d  = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // A write always wins over the clear of dirty at frame start.
        if (wr_accept) begin
            dirty_d = 1'b1;
        end
    end

    assign bus.char_valid_o  = valid_q;
    assign bus.char_data_o   = data_q;
    assign bus.char_addr_o   = addr_q;
    assign bus.frame_first_o = first_q;
    assign bus.frame_last_o  = last_q;
    assign clear_busy_o      = busy_q;

`ifdef OLED_TEXT_BUF_READBACK_EN
    // Direct combinational view of the cell array.
    assign rb_data_o = cells_q[rb_addr_i];
`endif

endmodule

// File: tb/tb_oled_text_buffer.sv
// Directed bench for oled_text_buffer: a cell-array model checks every beat,
// plus literal expectations for latency, frame counts and reset values.
module tb_oled_text_buffer;

    localparam logic [7:0] CLR = 8'h20;

    logic sysclk = 1'b0;
    logic rst_n;
    logic refresh1, refresh2;
    logic busy1, busy2;
    int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: high one cycle in three
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    oled_text_buffer_if if1 ();
    oled_text_buffer_if if2 ();

`ifdef OLED_TEXT_BUF_READBACK_EN
    logic [5:0] rb_addr1, rb_addr2;
    logic [7:0] rb_data1, rb_data2;
`endif

    always #5 sysclk = ~sysclk;

    oled_text_buffer #(.CLEAR_CHAR(CLR), .AUTO_REFRESH(1'b1)) dut (
        .sysclk       (sysclk),
        .cpu_resetn   (rst_n),
        .bus          (if1),
        .refresh_i    (refresh1),
        .clear_busy_o (busy1)
`ifdef OLED_TEXT_BUF_READBACK_EN
        ,
        .rb_addr_i    (rb_addr1),
        .rb_data_o    (rb_data1)
`endif
    );

    oled_text_buffer #(.CLEAR_CHAR(CLR), .AUTO_REFRESH(1'b0)) dut2 (
        .sysclk       (sysclk),
        .cpu_resetn   (rst_n),
        .bus          (if2),
        .refresh_i    (refresh2),
        .clear_busy_o (busy2)
`ifdef OLED_TEXT_BUF_READBACK_EN
        ,
        .rb_addr_i    (rb_addr2),
        .rb_data_o    (rb_data2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Ready pattern for the main instance.
    always @(posedge sysclk) begin
        cyc++;
        #1;
        if1.char_ready_i = (rdy_mode == 1) || ((rdy_mode == 2) && (cyc % 3 == 0));
    end

    // Model: expected cell contents; writes are lost while a clear is pending.
    logic [7:0] cells_m    [64];
    logic [7:0] cells_prev [64];
    int         clr_left = 64;

    always @(posedge sysclk) begin
        cells_prev = cells_m;
        if (!rst_n) begin
            clr_left = 64;
        end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) begin
                for (int i = 0; i < 64; i++) cells_m[i] = CLR;
            end
        end else if (if1.we_ip) begin
            cells_m[if1.write_addr_ip] = if1.write_data_ip;
        end
    end

    // Compare process for the main instance.
    logic       prev_v, prev_r, prev_f, prev_l;
    logic [7:0] prev_d;
    logic [5:0] prev_a;
    logic [5:0] exp_addr;
    logic [7:0] obs [64];
    int         frames = 0;

    always @(negedge sysclk) begin
        if (!rst_n) begin
            prev_v   = 1'b0;
            prev_r   = 1'b0;
            exp_addr = 6'd0;
        end else begin
            if (clr_left > 0) begin
                chk("valid_during_clear", if1.char_valid_o, 1'b0);
            end else if (prev_v && !prev_r) begin
                chk("stall_valid", if1.char_valid_o, 1'b1);
                chk("stall_data",  if1.char_data_o,  prev_d);
                chk("stall_addr",  if1.char_addr_o,  prev_a);
                chk("stall_first", if1.frame_first_o, prev_f);
                chk("stall_last",  if1.frame_last_o,  prev_l);
            end else if (if1.char_valid_o) begin
                chk("beat_addr",  if1.char_addr_o,  exp_addr);
                chk("beat_data",  if1.char_data_o,  cells_prev[exp_addr]);
                chk("beat_first", if1.frame_first_o, exp_addr == 6'd0);
                chk("beat_last",  if1.frame_last_o,  exp_addr == 6'd63);
            end else begin
                chk("idle_first_last", {if1.frame_first_o, if1.frame_last_o}, 2'b00);
            end
            if (if1.char_valid_o && if1.char_ready_i) begin
                obs[if1.char_addr_o] = if1.char_data_o;
                if (if1.char_addr_o == 6'd63) frames++;
                exp_addr = if1.char_addr_o + 6'd1;
            end
            prev_v = if1.char_valid_o;
            prev_r = if1.char_ready_i;
            prev_d = if1.char_data_o;
            prev_a = if1.char_addr_o;
            prev_f = if1.frame_first_o;
            prev_l = if1.frame_last_o;
        end
    end

    // Monitor for the manual-refresh instance: cell 7 holds 8'h66, rest clear.
    logic [5:0] exp2;
    int         beats2 = 0;
    int         frames2 = 0;

    always @(negedge sysclk) begin
        if (!rst_n) begin
            exp2 = 6'd0;
        end else if (if2.char_valid_o && if2.char_ready_i) begin
            chk("dut2_addr", if2.char_addr_o, exp2);
            chk("dut2_data", if2.char_data_o, (if2.char_addr_o == 6'd7) ? 8'h66 : CLR);
            beats2++;
            if (if2.char_addr_o == 6'd63) frames2++;
            exp2 = if2.char_addr_o + 6'd1;
        end
    end

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge sysclk);
            if (frames >= target) break;
        end
        chk("frame_wait", frames, target);
    endtask

    task automatic wait_beat(input logic [5:0] a);
        logic found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge sysclk);
            if (if1.char_valid_o && if1.char_addr_o == a) begin
                found = 1'b1;
                break;
            end
        end
        chk("beat_wait", found, 1'b1);
    endtask

    task automatic write1(input logic [5:0] a, input logic [7:0] d);
        @(posedge sysclk);
        #1;
        if1.we_ip = 1'b1; if1.write_addr_ip = a; if1.write_data_ip = d;
        @(posedge sysclk);
        #1;
        if1.we_ip = 1'b0;
    endtask

    initial begin
        int idx;
        int busy_cnt;
        int k;
        logic seen;

        rst_n = 1'b1;
        refresh1 = 1'b0; refresh2 = 1'b0;
        if1.we_ip = 1'b0; if1.write_addr_ip = '0; if1.write_data_ip = '0;
        if2.we_ip = 1'b0; if2.write_addr_ip = '0; if2.write_data_ip = '0;
        if2.char_ready_i = 1'b1;
`ifdef OLED_TEXT_BUF_READBACK_EN
        rb_addr1 = '0; rb_addr2 = '0;
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", if1.char_valid_o, 1'b0);
        chk("rst_data",  if1.char_data_o,  8'h00);
        chk("rst_addr",  if1.char_addr_o,  6'd0);
        chk("rst_busy",  busy1,            1'b1);

        // Release reset; a write at cycle 10 of the clear must be dropped.
        repeat (3) @(posedge sysclk);
        #1 rst_n = 1'b1;
        idx = 0; busy_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sysclk);
            if (if1.char_valid_o) begin seen = 1'b1; break; end
            if (busy1) busy_cnt++;
            if (idx == 10) begin if1.we_ip = 1'b1; if1.write_addr_ip = 6'd0; if1.write_data_ip = 8'h55; end
            if (idx == 11) if1.we_ip = 1'b0;
            idx++;
        end
        chk("first_frame_seen", seen, 1'b1);
        chk("clear_busy_cycles", busy_cnt, 64);
        chk("first_valid_cycle", idx, 66);
        wait_frames(1, 300);
        chk("f1_cell0", obs[0], 8'h20);
        chk("f1_cell63", obs[63], 8'h20);

        // Write 6'h3F in an idle cycle: first valid three cycles later.
        repeat (5) @(posedge sysclk);
        #1;
        if1.we_ip = 1'b1; if1.write_addr_ip = 6'h3F; if1.write_data_ip = 8'h2B;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge sysclk);
            #1 if1.we_ip = 1'b0;
            @(negedge sysclk);
            k++;
            if (if1.char_valid_o) break;
        end
        chk("write_to_valid_latency", k, 3);
        wait_frames(2, 300);
        repeat (150) @(posedge sysclk);
        chk("frames_after_write", frames, 2);
        chk("f2_cell63", obs[63], 8'h2B);
        chk("f2_cell62", obs[62], 8'h20);

        // Manual-refresh instance: dirty alone starts nothing; one pulse gives one frame.
        @(posedge sysclk);
        #1;
        if2.we_ip = 1'b1; if2.write_addr_ip = 6'd7; if2.write_data_ip = 8'h66;
        @(posedge sysclk);
        #1 if2.we_ip = 1'b0;
        repeat (30) @(posedge sysclk);
        chk("dut2_no_auto_frame", beats2, 0);
        #1 refresh2 = 1'b1;
        @(posedge sysclk);
        #1 refresh2 = 1'b0;
        repeat (40) @(posedge sysclk);
        #1 refresh2 = 1'b1;
        @(posedge sysclk);
        #1 refresh2 = 1'b0;
        repeat (250) @(posedge sysclk);
        chk("dut2_beats", beats2, 64);
        chk("dut2_frames", frames2, 1);

        // Backpressure one cycle in three.
        rdy_mode = 2;
        write1(6'd10, 8'h33);
        wait_frames(3, 600);
        rdy_mode = 1;
        repeat (150) @(posedge sysclk);
        chk("frames_backpressure", frames, 3);
        chk("f3_cell10", obs[10], 8'h33);

        // Write cell 5 while beat 10 is stalled: finish frame, then exactly one more.
        write1(6'd20, 8'h44);
        wait_beat(6'd9);
        rdy_mode = 0;
        wait_beat(6'd10);
        if1.we_ip = 1'b1; if1.write_addr_ip = 6'd5; if1.write_data_ip = 8'h41;
        @(negedge sysclk);
        if1.we_ip = 1'b0;
        rdy_mode = 1;
        wait_frames(4, 300);
        chk("f4_cell5_old", obs[5], 8'h20);
        wait_frames(5, 300);
        repeat (300) @(posedge sysclk);
        chk("frames_midframe_write", frames, 5);
        chk("f5_cell5", obs[5], 8'h41);
        chk("f5_cell20", obs[20], 8'h44);

        // Reset at beat 30 aborts the frame; next frame is all clear chars.
        write1(6'd1, 8'h77);
        wait_beat(6'd30);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", if1.char_valid_o, 1'b0);
        chk("abort_busy",  busy1,            1'b1);
        chk("abort_data",  if1.char_data_o,  8'h00);
        chk("abort_addr",  if1.char_addr_o,  6'd0);
        repeat (3) @(posedge sysclk);
        #1 rst_n = 1'b1;
        chk("frames_after_abort", frames, 5);
        wait_frames(6, 400);
        chk("f6_cell1", obs[1], 8'h20);
        chk("f6_cell30", obs[30], 8'h20);
`ifdef OLED_TEXT_BUF_READBACK_EN
        rb_addr1 = 6'd0;
        #1 chk("readback_addr0", rb_data1, 8'h20);
`endif
        repeat (5) @(posedge sysclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
